// File: rtl/ps2kbd_pkg.sv
// Shared types and constants for the PS/2 to Z88 key matrix front-end:
// FSM encodings, PS/2 prefix bytes, ignore list and matrix positions (row*8+col).
package ps2kbd_pkg;

   typedef enum logic [1:0] {
      FRM_IDLE,
      FRM_DATA,
      FRM_PAR,
      FRM_STOP
   } frm_state_t;

   typedef enum logic {
      DEC_NORM,
      DEC_SKIP
   } dec_state_t;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam logic [7:0] PS2_PAUSE = 8'hE1;

   // Pause sends E1 followed by seven more bytes that carry no key information
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   // Row 0 (ca[8])
   localparam logic [5:0] KEY_8        = 6'd0;
   localparam logic [5:0] KEY_7        = 6'd1;
   localparam logic [5:0] KEY_N        = 6'd2;
   localparam logic [5:0] KEY_H        = 6'd3;
   localparam logic [5:0] KEY_Y        = 6'd4;
   localparam logic [5:0] KEY_6        = 6'd5;
   localparam logic [5:0] KEY_ENTER    = 6'd6;
   localparam logic [5:0] KEY_DEL      = 6'd7;
   // Row 1
   localparam logic [5:0] KEY_I        = 6'd8;
   localparam logic [5:0] KEY_U        = 6'd9;
   localparam logic [5:0] KEY_B        = 6'd10;
   localparam logic [5:0] KEY_G        = 6'd11;
   localparam logic [5:0] KEY_T        = 6'd12;
   localparam logic [5:0] KEY_5        = 6'd13;
   localparam logic [5:0] KEY_UP       = 6'd14;
   localparam logic [5:0] KEY_BSLASH   = 6'd15;
   // Row 2
   localparam logic [5:0] KEY_O        = 6'd16;
   localparam logic [5:0] KEY_J        = 6'd17;
   localparam logic [5:0] KEY_V        = 6'd18;
   localparam logic [5:0] KEY_F        = 6'd19;
   localparam logic [5:0] KEY_R        = 6'd20;
   localparam logic [5:0] KEY_4        = 6'd21;
   localparam logic [5:0] KEY_DOWN     = 6'd22;
   localparam logic [5:0] KEY_EQUAL    = 6'd23;
   // Row 3
   localparam logic [5:0] KEY_9        = 6'd24;
   localparam logic [5:0] KEY_K        = 6'd25;
   localparam logic [5:0] KEY_C        = 6'd26;
   localparam logic [5:0] KEY_D        = 6'd27;
   localparam logic [5:0] KEY_E        = 6'd28;
   localparam logic [5:0] KEY_3        = 6'd29;
   localparam logic [5:0] KEY_RIGHT    = 6'd30;
   localparam logic [5:0] KEY_MINUS    = 6'd31;
   // Row 4
   localparam logic [5:0] KEY_P        = 6'd32;
   localparam logic [5:0] KEY_M        = 6'd33;
   localparam logic [5:0] KEY_X        = 6'd34;
   localparam logic [5:0] KEY_S        = 6'd35;
   localparam logic [5:0] KEY_W        = 6'd36;
   localparam logic [5:0] KEY_A        = 6'd37;
   localparam logic [5:0] KEY_LEFT     = 6'd38;
   localparam logic [5:0] KEY_RBRACKET = 6'd39;
   // Row 5
   localparam logic [5:0] KEY_0        = 6'd40;
   localparam logic [5:0] KEY_L        = 6'd41;
   localparam logic [5:0] KEY_Z        = 6'd42;
   localparam logic [5:0] KEY_2        = 6'd43;
   localparam logic [5:0] KEY_Q        = 6'd44;
   localparam logic [5:0] KEY_1        = 6'd45;
   localparam logic [5:0] KEY_SPACE    = 6'd46;
   localparam logic [5:0] KEY_LBRACKET = 6'd47;
   // Row 6
   localparam logic [5:0] KEY_APOS     = 6'd48;
   localparam logic [5:0] KEY_SEMI     = 6'd49;
   localparam logic [5:0] KEY_COMMA    = 6'd50;
   localparam logic [5:0] KEY_MENU     = 6'd51;
   localparam logic [5:0] KEY_DIAMOND  = 6'd52;
   localparam logic [5:0] KEY_TAB      = 6'd53;
   localparam logic [5:0] KEY_SQUARE   = 6'd54;
   localparam logic [5:0] KEY_HELP     = 6'd55;
   // Row 7
   localparam logic [5:0] KEY_POUND    = 6'd56;
   localparam logic [5:0] KEY_SLASH    = 6'd57;
   localparam logic [5:0] KEY_PERIOD   = 6'd58;
   localparam logic [5:0] KEY_CAPS     = 6'd59;
   localparam logic [5:0] KEY_INDEX    = 6'd60;
   localparam logic [5:0] KEY_ESC      = 6'd61;
   localparam logic [5:0] KEY_LSHIFT   = 6'd62;
   localparam logic [5:0] KEY_RSHIFT   = 6'd63;

   // Keyboard status/ack codes that also cancel any pending prefix
   function automatic logic is_ignored(input logic [7:0] code);
      case (code)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: return 1'b1;
         default:                                  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ps2kbd_keymap.sv
// Combinational scancode ROM: {ext, set-2 code} -> {valid, Z88 matrix index}.
module ps2kbd_keymap
   import ps2kbd_pkg::*;
(
   input  logic       ext,
   input  logic [7:0] code,
   output logic       valid,
   output logic [5:0] idx
);

   always_comb begin
      valid = 1'b1;
      idx   = '0;
      case ({ext, code})
         9'h01C: idx = KEY_A;
         9'h032: idx = KEY_B;
         9'h021: idx = KEY_C;
         9'h023: idx = KEY_D;
         9'h024: idx = KEY_E;
         9'h02B: idx = KEY_F;
         9'h034: idx = KEY_G;
         9'h033: idx = KEY_H;
         9'h043: idx = KEY_I;
         9'h03B: idx = KEY_J;
         9'h042: idx = KEY_K;
         9'h04B: idx = KEY_L;
         9'h03A: idx = KEY_M;
         9'h031: idx = KEY_N;
         9'h044: idx = KEY_O;
         9'h04D: idx = KEY_P;
         9'h015: idx = KEY_Q;
         9'h02D: idx = KEY_R;
         9'h01B: idx = KEY_S;
         9'h02C: idx = KEY_T;
         9'h03C: idx = KEY_U;
         9'h02A: idx = KEY_V;
         9'h01D: idx = KEY_W;
         9'h022: idx = KEY_X;
         9'h035: idx = KEY_Y;
         9'h01A: idx = KEY_Z;
         9'h045: idx = KEY_0;
         9'h016: idx = KEY_1;
         9'h01E: idx = KEY_2;
         9'h026: idx = KEY_3;
         9'h025: idx = KEY_4;
         9'h02E: idx = KEY_5;
         9'h036: idx = KEY_6;
         9'h03D: idx = KEY_7;
         9'h03E: idx = KEY_8;
         9'h046: idx = KEY_9;
         9'h05A: idx = KEY_ENTER;
         9'h066: idx = KEY_DEL;
         9'h029: idx = KEY_SPACE;
         9'h00D: idx = KEY_TAB;
         9'h076: idx = KEY_ESC;
         9'h012: idx = KEY_LSHIFT;
         9'h059: idx = KEY_RSHIFT;
         9'h058: idx = KEY_CAPS;
         9'h04E: idx = KEY_MINUS;
         9'h055: idx = KEY_EQUAL;
         9'h054: idx = KEY_LBRACKET;
         9'h05B: idx = KEY_RBRACKET;
         9'h05D: idx = KEY_BSLASH;
         9'h04C: idx = KEY_SEMI;
         9'h052: idx = KEY_APOS;
         9'h041: idx = KEY_COMMA;
         9'h049: idx = KEY_PERIOD;
         9'h04A: idx = KEY_SLASH;
         9'h00E: idx = KEY_POUND;
         // F1..F3 and the modifier keys stand in for the Z88 special keys
         9'h005: idx = KEY_HELP;
         9'h006: idx = KEY_INDEX;
         9'h004: idx = KEY_MENU;
         9'h014: idx = KEY_DIAMOND;
         9'h011: idx = KEY_SQUARE;
         9'h175: idx = KEY_UP;
         9'h172: idx = KEY_DOWN;
         9'h16B: idx = KEY_LEFT;
         9'h174: idx = KEY_RIGHT;
         9'h15A: idx = KEY_ENTER;
         9'h171: idx = KEY_DEL;
         9'h114: idx = KEY_DIAMOND;
         9'h111: idx = KEY_SQUARE;
         default: valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/ps2_kbmat.sv
// PS/2 keyboard receiver producing the live 64-bit Z88 key matrix in the mck domain.
// Define PS2KBD_PARITY_CHK_EN to reject frames whose odd parity does not check.
module ps2_kbmat
   import ps2kbd_pkg::*;
#(
   parameter int FILT_LEN = 8,
   parameter int TIMEOUT  = 9830
)(
   input  logic        mck,
   input  logic        rin,
   input  logic        ps2_clk,
   input  logic        ps2_dat,
   input  logic        clr_all,
   output logic [63:0] kbmat,
   output logic        key_evt,
   output logic        frm_err
);

   localparam int FW = $clog2(FILT_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [1:0]    clk_s, dat_s;
   logic          filt_clk;
   logic [FW-1:0] filt_cnt;
   logic          fall, fall_dat;

   frm_state_t    frm_state;
   logic [7:0]    shreg, rx_byte;
   logic [2:0]    bit_cnt;
   logic [TW-1:0] tmo_cnt;
   logic          byte_v, tmo;
`ifdef PS2KBD_PARITY_CHK_EN
   logic          par_bit;
`endif

   dec_state_t    dec_state;
   logic [2:0]    skip_cnt;
   logic          ext, brk;
   logic          map_valid;
   logic [5:0]    map_idx;
   logic          lk_v, lk_make;
   logic [5:0]    lk_idx;

   // Synchronise both lines; the clock level moves only after FILT_LEN agreeing samples
   always_ff @(posedge mck) begin
      if (rin) begin
         clk_s    <= 2'b11;
         dat_s    <= 2'b11;
         filt_clk <= 1'b1;
         filt_cnt <= '0;
         fall     <= 1'b0;
         fall_dat <= 1'b0;
      end else begin
         clk_s <= {clk_s[0], ps2_clk};
         dat_s <= {dat_s[0], ps2_dat};
         fall  <= 1'b0;
         if (clk_s[1] == filt_clk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
            filt_clk <= clk_s[1];
            filt_cnt <= '0;
            fall     <= ~clk_s[1];
            fall_dat <= dat_s[1];
         end else begin
            filt_cnt <= filt_cnt + FW'(1);
         end
      end
   end

   // Frame FSM; a stalled frame is abandoned after TIMEOUT cycles without a fall
   always_ff @(posedge mck) begin
      if (rin) begin
         frm_state <= FRM_IDLE;
         shreg     <= '0;
         rx_byte   <= '0;
         bit_cnt   <= '0;
         tmo_cnt   <= '0;
         byte_v    <= 1'b0;
         tmo       <= 1'b0;
         frm_err   <= 1'b0;
`ifdef PS2KBD_PARITY_CHK_EN
         par_bit   <= 1'b0;
`endif
      end else begin
         byte_v  <= 1'b0;
         tmo     <= 1'b0;
         frm_err <= 1'b0;
         if (fall || frm_state == FRM_IDLE)
            tmo_cnt <= '0;
         else
            tmo_cnt <= tmo_cnt + TW'(1);

         if (!fall && frm_state != FRM_IDLE && tmo_cnt == TW'(TIMEOUT - 1)) begin
            frm_state <= FRM_IDLE;
            frm_err   <= 1'b1;
            tmo       <= 1'b1;
         end else if (fall) begin
            unique case (frm_state)
               FRM_IDLE: begin
                  if (!fall_dat) begin
                     frm_state <= FRM_DATA;
                     bit_cnt   <= '0;
                  end
               end
               FRM_DATA: begin
                  shreg   <= {fall_dat, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7)
                     frm_state <= FRM_PAR;
               end
               FRM_PAR: begin
`ifdef PS2KBD_PARITY_CHK_EN
                  par_bit <= fall_dat;
`endif
                  frm_state <= FRM_STOP;
               end
               FRM_STOP: begin
                  frm_state <= FRM_IDLE;
`ifdef PS2KBD_PARITY_CHK_EN
                  if (fall_dat && (^{shreg, par_bit})) begin
`else
                  if (fall_dat) begin
`endif
                     byte_v  <= 1'b1;
                     rx_byte <= shreg;
                  end else begin
                     frm_err <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

   ps2kbd_keymap u_keymap (
      .ext   (ext),
      .code  (rx_byte),
      .valid (map_valid),
      .idx   (map_idx)
   );

   // Decoder: prefix tracking, pause skipping and the registered keymap lookup
   always_ff @(posedge mck) begin
      if (rin) begin
         dec_state <= DEC_NORM;
         skip_cnt  <= '0;
         ext       <= 1'b0;
         brk       <= 1'b0;
         lk_v      <= 1'b0;
         lk_idx    <= '0;
         lk_make   <= 1'b0;
      end else begin
         lk_v <= 1'b0;
         if (tmo) begin
            ext <= 1'b0;
            brk <= 1'b0;
         end else if (byte_v) begin
            if (dec_state == DEC_SKIP) begin
               skip_cnt <= skip_cnt - 3'd1;
               if (skip_cnt == 3'd1)
                  dec_state <= DEC_NORM;
            end else if (rx_byte == PS2_EXT) begin
               ext <= 1'b1;
            end else if (rx_byte == PS2_BRK) begin
               brk <= 1'b1;
            end else if (rx_byte == PS2_PAUSE) begin
               dec_state <= DEC_SKIP;
               skip_cnt  <= PAUSE_SKIP;
               ext       <= 1'b0;
               brk       <= 1'b0;
            end else begin
               ext <= 1'b0;
               brk <= 1'b0;
               if (!is_ignored(rx_byte)) begin
                  lk_v    <= map_valid;
                  lk_idx  <= map_idx;
                  lk_make <= ~brk;
               end
            end
         end
      end
   end

   // clr_all wins over a same-cycle key update and suppresses its event
   always_ff @(posedge mck) begin
      if (rin) begin
         kbmat   <= '0;
         key_evt <= 1'b0;
      end else begin
         key_evt <= 1'b0;
         if (clr_all) begin
            kbmat <= '0;
         end else if (lk_v) begin
            kbmat[lk_idx] <= lk_make;
            key_evt       <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ps2_kbmat.sv
// Directed self-checking bench for ps2_kbmat: drives PS/2 frames and checks
// the key matrix, key_evt and frm_err pulse counts against hand-computed values.
`timescale 1ns/1ps
module tb_ps2_kbmat;

   localparam int HALF    = 20;
   localparam int TIMEOUT = 9830;

   localparam logic [63:0] B_ENTER  = 64'd1 << 6;
   localparam logic [63:0] B_UP     = 64'd1 << 14;
   localparam logic [63:0] B_A      = 64'd1 << 37;
   localparam logic [63:0] B_LSHIFT = 64'd1 << 62;

   logic        mck     = 1'b0;
   logic        rin     = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_dat = 1'b1;
   logic        clr_all = 1'b0;
   logic [63:0] kbmat;
   logic        key_evt;
   logic        frm_err;

   int errors  = 0;
   int checks  = 0;
   int evt_cnt = 0;
   int err_cnt = 0;

   ps2_kbmat #(
      .FILT_LEN (8),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .mck     (mck),
      .rin     (rin),
      .ps2_clk (ps2_clk),
      .ps2_dat (ps2_dat),
      .clr_all (clr_all),
      .kbmat   (kbmat),
      .key_evt (key_evt),
      .frm_err (frm_err)
   );

   always #5 mck = ~mck;

   // Pulse counters sampled away from the active edge
   always @(negedge mck) begin
      if (key_evt) evt_cnt++;
      if (frm_err) err_cnt++;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge mck);
   endtask

   task automatic ps2_bit(input logic b);
      ps2_dat = b;
      idle(HALF);
      ps2_clk = 1'b0;
      idle(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] code, input logic bad_par,
                             input logic stop, input logic clr_at_stop);
      logic par;
      par = (~^code) ^ bad_par;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(code[i]);
      ps2_bit(par);
      ps2_dat = stop;
      idle(HALF);
      ps2_clk = 1'b0;
      if (clr_at_stop) clr_all = 1'b1;
      idle(HALF);
      clr_all = 1'b0;
      ps2_clk = 1'b1;
      ps2_dat = 1'b1;
      idle(HALF);
   endtask

   task automatic send(input logic [7:0] code);
      send_frame(code, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_reset();
      rin = 1'b1;
      idle(5);
      checks++;
      if (kbmat !== 64'd0) begin
         errors++;
         $display("[TB] FAIL reset_kbmat: got %h want %h", kbmat, 64'd0);
      end
      checks++;
      if (key_evt !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_key_evt: got %b want 0", key_evt);
      end
      checks++;
      if (frm_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_frm_err: got %b want 0", frm_err);
      end
      rin = 1'b0;
      idle(5);
   endtask

   task automatic test_make_break();
      int e0, f0;
      e0 = evt_cnt;
      f0 = err_cnt;
      send(8'h1C);
      checks++;
      if (kbmat !== B_A) begin
         errors++;
         $display("[TB] FAIL make_a: got %h want %h", kbmat, B_A);
      end
      checks++;
      if (evt_cnt - e0 !== 1) begin
         errors++;
         $display("[TB] FAIL make_a_evt: got %0d want 1", evt_cnt - e0);
      end
      send(8'hF0);
      send(8'h1C);
      checks++;
      if (kbmat !== 64'd0) begin
         errors++;
         $display("[TB] FAIL break_a: got %h want %h", kbmat, 64'd0);
      end
      checks++;
      if (evt_cnt - e0 !== 2) begin
         errors++;
         $display("[TB] FAIL break_a_evt: got %0d want 2", evt_cnt - e0);
      end
      checks++;
      if (err_cnt - f0 !== 0) begin
         errors++;
         $display("[TB] FAIL make_break_frm_err: got %0d want 0", err_cnt - f0);
      end
   endtask

   task automatic test_ext_shift();
      int e0;
      e0 = evt_cnt;
      send(8'h12);
      send(8'hE0);
      send(8'h75);
      checks++;
      if (kbmat !== (B_LSHIFT | B_UP)) begin
         errors++;
         $display("[TB] FAIL ext_make: got %h want %h", kbmat, B_LSHIFT | B_UP);
      end
      checks++;
      if (evt_cnt - e0 !== 2) begin
         errors++;
         $display("[TB] FAIL ext_make_evt: got %0d want 2", evt_cnt - e0);
      end
      send(8'hE0);
      send(8'hF0);
      send(8'h75);
      checks++;
      if (kbmat !== B_LSHIFT) begin
         errors++;
         $display("[TB] FAIL ext_break: got %h want %h", kbmat, B_LSHIFT);
      end
      checks++;
      if (evt_cnt - e0 !== 3) begin
         errors++;
         $display("[TB] FAIL ext_break_evt: got %0d want 3", evt_cnt - e0);
      end
   endtask

   task automatic test_glitch_timeout();
      int e0, f0;
      e0 = evt_cnt;
      f0 = err_cnt;
      ps2_dat = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ps2_clk = 1'b0;
         idle(1);
         ps2_clk = 1'b1;
         idle(12);
      end
      ps2_clk = 1'b0;
      idle(7);
      ps2_clk = 1'b1;
      idle(12);
      ps2_dat = 1'b1;
      idle(12);
      checks++;
      if (err_cnt - f0 !== 0) begin
         errors++;
         $display("[TB] FAIL glitch_frm_err: got %0d want 0", err_cnt - f0);
      end
      checks++;
      if (kbmat !== B_LSHIFT) begin
         errors++;
         $display("[TB] FAIL glitch_kbmat: got %h want %h", kbmat, B_LSHIFT);
      end
      // A break prefix followed by an aborted frame must not turn 5A into a break
      send(8'hF0);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      ps2_dat = 1'b1;
      idle(TIMEOUT + 200);
      checks++;
      if (err_cnt - f0 !== 1) begin
         errors++;
         $display("[TB] FAIL timeout_frm_err: got %0d want 1", err_cnt - f0);
      end
      send(8'h5A);
      checks++;
      if (kbmat !== (B_LSHIFT | B_ENTER)) begin
         errors++;
         $display("[TB] FAIL after_timeout_kbmat: got %h want %h", kbmat, B_LSHIFT | B_ENTER);
      end
      checks++;
      if (evt_cnt - e0 !== 1) begin
         errors++;
         $display("[TB] FAIL after_timeout_evt: got %0d want 1", evt_cnt - e0);
      end
   endtask

   task automatic test_framing_pause();
      int e0, f0;
      logic [7:0] pause_seq [8];
      pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      e0 = evt_cnt;
      f0 = err_cnt;
      send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
      checks++;
      if (err_cnt - f0 !== 1) begin
         errors++;
         $display("[TB] FAIL bad_stop_frm_err: got %0d want 1", err_cnt - f0);
      end
      checks++;
      if (kbmat !== (B_LSHIFT | B_ENTER)) begin
         errors++;
         $display("[TB] FAIL bad_stop_kbmat: got %h want %h", kbmat, B_LSHIFT | B_ENTER);
      end
      for (int i = 0; i < 8; i++) send(pause_seq[i]);
      checks++;
      if (kbmat !== (B_LSHIFT | B_ENTER)) begin
         errors++;
         $display("[TB] FAIL pause_kbmat: got %h want %h", kbmat, B_LSHIFT | B_ENTER);
      end
      checks++;
      if (evt_cnt - e0 !== 0) begin
         errors++;
         $display("[TB] FAIL pause_evt: got %0d want 0", evt_cnt - e0);
      end
      checks++;
      if (err_cnt - f0 !== 1) begin
         errors++;
         $display("[TB] FAIL pause_frm_err: got %0d want 1", err_cnt - f0);
      end
   endtask

   task automatic test_parity();
      int e0, f0;
      e0 = evt_cnt;
      f0 = err_cnt;
      send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
`ifdef PS2KBD_PARITY_CHK_EN
      checks++;
      if (kbmat !== (B_LSHIFT | B_ENTER)) begin
         errors++;
         $display("[TB] FAIL bad_parity_kbmat: got %h want %h", kbmat, B_LSHIFT | B_ENTER);
      end
      checks++;
      if (err_cnt - f0 !== 1) begin
         errors++;
         $display("[TB] FAIL bad_parity_frm_err: got %0d want 1", err_cnt - f0);
      end
`else
      checks++;
      if (kbmat !== (B_LSHIFT | B_ENTER | B_A)) begin
         errors++;
         $display("[TB] FAIL bad_parity_kbmat: got %h want %h", kbmat, B_LSHIFT | B_ENTER | B_A);
      end
      checks++;
      if (err_cnt - f0 !== 0) begin
         errors++;
         $display("[TB] FAIL bad_parity_frm_err: got %0d want 0", err_cnt - f0);
      end
`endif
      send(8'h1C);
      checks++;
      if (kbmat !== (B_LSHIFT | B_ENTER | B_A)) begin
         errors++;
         $display("[TB] FAIL good_parity_kbmat: got %h want %h", kbmat, B_LSHIFT | B_ENTER | B_A);
      end
`ifdef PS2KBD_PARITY_CHK_EN
      checks++;
      if (evt_cnt - e0 !== 1) begin
         errors++;
         $display("[TB] FAIL parity_evt: got %0d want 1", evt_cnt - e0);
      end
`else
      checks++;
      if (evt_cnt - e0 !== 2) begin
         errors++;
         $display("[TB] FAIL parity_evt: got %0d want 2", evt_cnt - e0);
      end
`endif
   endtask

   task automatic test_clr_all();
      int e0;
      e0 = evt_cnt;
      send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
      checks++;
      if (kbmat !== 64'd0) begin
         errors++;
         $display("[TB] FAIL clr_all_kbmat: got %h want %h", kbmat, 64'd0);
      end
      checks++;
      if (evt_cnt - e0 !== 0) begin
         errors++;
         $display("[TB] FAIL clr_all_evt: got %0d want 0", evt_cnt - e0);
      end
   endtask

   task automatic test_reset_midframe();
      int e0, f0;
      send(8'h12);
      checks++;
      if (kbmat !== B_LSHIFT) begin
         errors++;
         $display("[TB] FAIL pre_reset_kbmat: got %h want %h", kbmat, B_LSHIFT);
      end
      ps2_bit(1'b0);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      rin = 1'b1;
      idle(3);
      rin = 1'b0;
      idle(5);
      e0 = evt_cnt;
      f0 = err_cnt;
      send(8'h1C);
      checks++;
      if (kbmat !== B_A) begin
         errors++;
         $display("[TB] FAIL post_reset_kbmat: got %h want %h", kbmat, B_A);
      end
      checks++;
      if (evt_cnt - e0 !== 1) begin
         errors++;
         $display("[TB] FAIL post_reset_evt: got %0d want 1", evt_cnt - e0);
      end
      checks++;
      if (err_cnt - f0 !== 0) begin
         errors++;
         $display("[TB] FAIL post_reset_frm_err: got %0d want 0", err_cnt - f0);
      end
   endtask

   initial begin
      test_reset();
      test_make_break();
      test_ext_shift();
      test_glitch_timeout();
      test_framing_pause();
      test_parity();
      test_clr_all();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ps2_kbmat.md
Name: ps2_kbmat

Overview:
- Upstream keyboard front-end for the blink. Converts a host PS/2 keyboard stream into the 64-bit Z88 key matrix `kbmat` that the blink reads through port $B2.
- Deserialises PS/2 frames, tracks the E0/F0/E1 prefixes, and maps each scancode to a matrix position.
- Holds a live pressed/released bit per matrix key.
- Clocked by the blink master clock so that `kbmat` is synchronous to the consumer.

Parameters:
- FILT_LEN, 8: consecutive identical `ps2_clk` samples needed to accept a new filtered level.
- TIMEOUT, 9830: mck cycles without a falling edge before an in-progress frame is aborted (about 1 ms at 9.83 MHz).

Ports:
- mck, input, 1: master clock, 9.83 MHz.
- rin, input, 1: reset; synchronous, active-high.
- ps2_clk, input, 1: raw PS/2 clock, asynchronous.
- ps2_dat, input, 1: raw PS/2 data, asynchronous.
- clr_all, input, 1: synchronous pulse that releases all keys.
- kbmat, output, 64: key matrix. Bit `row*8+col` is 1 when the key is pressed; row r is selected by ca[8+r].
- key_evt, output, 1: one-cycle pulse when `kbmat` changes because of a make or break code.
- frm_err, output, 1: one-cycle pulse on a framing error or timeout.

Behaviour:
- Reset (`rin`=1 at a mck edge):
  - kbmat=0, key_evt=0, frm_err=0.
  - Both FSMs go to IDLE; prefix flags and counters are cleared.
  - Reset mid-frame discards the partial byte.
- Input conditioning:
  - 2-flop synchroniser on `ps2_clk` and `ps2_dat`.
  - Glitch filter on the clock: the filtered level changes only after FILT_LEN equal samples.
  - A falling edge of the filtered clock (fall) samples the synchronised data.
- Frame FSM (IDLE, DATA, PAR, STOP):
  - IDLE: on fall with data=0 go to DATA. A start bit of 1 is ignored and the FSM stays in IDLE.
  - DATA: shift 8 bits in, LSB first. A 3-bit counter moves to PAR after the 8th bit.
  - PAR: latch the parity bit, then go to STOP.
  - STOP: on fall, data=1 makes the byte valid (byte_v pulses the next cycle). Data=0 pulses frm_err with no byte. Either way return to IDLE.
  - Timeout: the idle counter resets on every fall. If it reaches TIMEOUT outside IDLE: go to IDLE, pulse frm_err, drop the byte.
- Decoder FSM (NORM, SKIP), acting on byte_v:
  - E0: set ext.
  - F0: set brk.
  - E1: enter SKIP and ignore the next 7 bytes; a 3-bit counter returns to NORM. Pause is unmapped.
  - 00, AA, EE, FA, FE, FF: ignored; ext and brk are cleared.
  - Any other code: look up {ext, code} in the keymap. The lookup result is registered at byte_v+1.
    - If valid: at byte_v+2, `kbmat[idx]` <= !brk and key_evt=1.
    - If invalid: no update.
    - In both cases clear ext and brk.
  - Latency: kbmat updates 3 mck cycles after the stop-bit fall is detected.
  - key_evt fires even when the bit already holds that value, e.g. typematic repeat or a break for an unpressed key.
- Simultaneous events:
  - clr_all clears kbmat. Any update in the same cycle is discarded and key_evt stays 0.
  - `rin` overrides everything.
- Prefix flags persist across a timeout only until the next decoded byte; a timeout itself clears ext and brk.

Optional Feature:
- Macro: PS2KBD_PARITY_CHK_EN.
- Defined: at STOP, odd parity over data+parity is checked. A mismatch drops the byte and pulses frm_err (same cycle a valid stop would have asserted byte_v).
- Undefined: the parity bit is sampled and ignored; only start, stop and timeout errors exist.

Decomposition:
- Package ps2kbd_pkg:
  - Frame and decoder FSM state encodings.
  - Prefix constants: PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1.
  - Ignore-code list.
  - Matrix index constants: KEY_ENTER=6'd6, KEY_UP=6'd14, KEY_A=6'd37, KEY_LSHIFT=6'd62, plus the remaining 60.
- Sub-module ps2kbd_keymap:
  - Purely combinational ROM: {ext, code[7:0]} -> {valid, idx[5:0]}.
  - Contents come from package constants.
  - Required entries: 1C->KEY_A, 5A->KEY_ENTER, 12->KEY_LSHIFT, E0+75->KEY_UP.
  - E0+5A (keypad enter) also maps to KEY_ENTER.

Test Plan:
- Make/break A: frame 1C, then frames F0 and 1C -> kbmat[37]=1 three cycles after the first stop bit, with one key_evt; then kbmat[37]=0 with a second key_evt; frm_err stays 0.
- Extended key plus shift: 12, E0, 75 -> kbmat[62]=1 and kbmat[14]=1. Then E0, F0, 75 -> kbmat[14]=0 and kbmat[62]=1.
- Glitch and timeout: 1-cycle pulses on ps2_clk with FILT_LEN=8 -> no state change. Send 5 data bits then idle 9830 cycles -> one frm_err pulse, FSM in IDLE. The next full frame 5A sets kbmat[6].
- Framing and pause: stop bit=0 -> frm_err and no update. E1 14 77 E1 F0 14 F0 77 -> kbmat unchanged and no key_evt.
- Parity, with PS2KBD_PARITY_CHK_EN: frame 1C with bad parity -> frm_err and kbmat[37] stays 0. Without the macro, the same frame sets kbmat[37].
- clr_all and reset: with kbmat[37], [62] and [6] set, pulse clr_all in the same cycle as a 5A update -> kbmat=0 and no key_evt. Assert rin mid-frame, then send a complete 1C -> only kbmat[37] set.
